// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V main control FSM:
// state numbering, opcode constants, ALU select codes and the control word.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_MEMADDR  = 4'd4,
        ST_BRANCH   = 4'd5,
        ST_RWB      = 4'd6,
        ST_MEMREAD  = 4'd7,
        ST_MEMWRITE = 4'd8,
        ST_ILLEGAL  = 4'd9,
        ST_MEMWB    = 4'd10
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // Unqualified control word; pc_write, ir_write and done_on_ready are
    // gated by mem_ready at the top level.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       memtoreg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_source;
        logic       instr_done;
        logic       done_on_ready;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Purely combinational decode of the FSM state into the datapath control word.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t i_state,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.ir_write  = 1'b1;
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALU_ADD;
            end
            ST_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_ADD;
            end
            ST_EXEC_R: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_RS2;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            ST_RWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            ST_MEMADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_ADD;
            end
            ST_MEMREAD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            ST_MEMWRITE: begin
                o_ctrl.mem_write     = 1'b1;
                o_ctrl.iord          = 1'b1;
                o_ctrl.done_on_ready = 1'b1;
            end
            ST_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.memtoreg   = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_RS2;
                o_ctrl.alu_op        = ALU_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = 1'b1;
                o_ctrl.instr_done    = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle core: state register, next-state logic,
// mem_ready qualification of strobes and the sticky illegal-opcode flag.
module multicycle_control
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Opcode,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t r_state;
    state_t w_next;
    logic   r_is_store;
    logic   r_illegal;
    ctrl_t  w_ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RESET;
            r_is_store <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_state <= w_next;
            // Opcode is only trusted in DECODE; remember load vs store for MEMADDR.
            if (r_state == ST_DECODE) begin
                r_is_store <= (Opcode == OP_STORE);
            end
            if (w_next == ST_ILLEGAL) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RESET:   w_next = ST_FETCH;
            ST_FETCH:   if (mem_ready) w_next = ST_DECODE;
            ST_DECODE: begin
                case (Opcode)
                    OP_R:               w_next = ST_EXEC_R;
                    OP_LOAD, OP_STORE:  w_next = ST_MEMADDR;
                    OP_BRANCH:          w_next = ST_BRANCH;
                    default:            w_next = ST_ILLEGAL;
                endcase
            end
            ST_EXEC_R:   w_next = ST_RWB;
            ST_RWB:      w_next = ST_FETCH;
            ST_MEMADDR:  w_next = r_is_store ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD:  if (mem_ready) w_next = ST_MEMWB;
            ST_MEMWRITE: if (mem_ready) w_next = ST_FETCH;
            ST_MEMWB:    w_next = ST_FETCH;
            ST_BRANCH:   w_next = ST_FETCH;
            ST_ILLEGAL:  w_next = ST_ILLEGAL;
            default:     w_next = ST_RESET;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

    assign PCEn       = (w_ctrl.pc_write & mem_ready) | (w_ctrl.pc_write_cond & Zero);
    assign IRWrite    = w_ctrl.ir_write & mem_ready;
    assign instr_done = w_ctrl.instr_done | (w_ctrl.done_on_ready & mem_ready);
    assign IorD       = w_ctrl.iord;
    assign MemRead    = w_ctrl.mem_read;
    assign MemWrite   = w_ctrl.mem_write;
    assign MemtoReg   = w_ctrl.memtoreg;
    assign RegWrite   = w_ctrl.reg_write;
    assign ALUSrcA    = w_ctrl.alu_src_a;
    assign ALUSrcB    = w_ctrl.alu_src_b;
    assign ALUOp      = w_ctrl.alu_op;
    assign PCSource   = w_ctrl.pc_source;
    assign illegal_op = r_illegal;
    assign state      = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, hand sequences for
// wait/illegal/reset corners, and a randomized instruction stream.
module tb_multicycle_control;

    localparam logic [6:0] T_OP_R   = 7'b0110011;
    localparam logic [6:0] T_OP_LD  = 7'b0000011;
    localparam logic [6:0] T_OP_ST  = 7'b0100011;
    localparam logic [6:0] T_OP_BEQ = 7'b1100011;

    logic       clk;
    logic       reset;
    logic [6:0] Opcode;
    logic       Zero;
    logic       mem_ready;
    logic       PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite;
    logic       ALUSrcA, PCSource, instr_done, illegal_op;
    logic [1:0] ALUSrcB, ALUOp;
    logic [3:0] state;
    logic [18:0] w_obs;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .Opcode     (Opcode),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCEn       (PCEn),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSource   (PCSource),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .state      (state)
    );

    assign w_obs = {PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
                    ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op, state};

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Reference: expected control outputs for a step, straight from the state table.
    function automatic logic [18:0] exp_out(input logic [3:0] st, input logic mr, input logic z);
        logic pcen, iord, mrd, mwr, irw, m2r, rw, sa, pcs, dn, ill;
        logic [1:0] sb, op;
        {pcen, iord, mrd, mwr, irw, m2r, rw, sa, pcs, dn, ill} = '0;
        sb = 2'b00;
        op = 2'b00;
        case (st)
            4'd1:  begin mrd = 1; sb = 2'b01; irw = mr; pcen = mr; end
            4'd2:  begin sb = 2'b10; end
            4'd3:  begin sa = 1; op = 2'b10; end
            4'd4:  begin sa = 1; sb = 2'b10; end
            4'd5:  begin sa = 1; op = 2'b01; pcs = 1; dn = 1; pcen = z; end
            4'd6:  begin rw = 1; dn = 1; end
            4'd7:  begin mrd = 1; iord = 1; end
            4'd8:  begin mwr = 1; iord = 1; dn = mr; end
            4'd9:  begin ill = 1; end
            4'd10: begin rw = 1; m2r = 1; dn = 1; end
            default: ;
        endcase
        return {pcen, iord, mrd, mwr, irw, m2r, rw, sa, sb, op, pcs, dn, ill, st};
    endfunction

    // Scoreboard compare
    task automatic check(input string nm, input logic [18:0] exp);
        n_tests++;
        if (w_obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h (state got %0d want %0d)",
                     nm, w_obs, exp, w_obs[3:0], exp[3:0]);
        end
    endtask

    // Driver: called at posedge+1, applies inputs, checks mid-cycle, advances.
    task automatic step(input string nm, input logic [3:0] st, input logic mr,
                        input logic [6:0] op);
        mem_ready = mr;
        Opcode    = op;
        Zero      = 1'($urandom_range(0, 1));
        #4;
        check(nm, exp_out(st, mr, Zero));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] rnd_op();
        return 7'($urandom_range(0, 127));
    endfunction

    task automatic do_reset(input string nm);
        reset = 1'b1;
        #4;
        check(nm, exp_out(4'd0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        #3;
        check(nm, exp_out(4'd0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
    endtask

    // Instruction-level model: expand one instruction into its expected steps.
    task automatic run_instr(input int cls, input int fw, input int mw, input string nm);
        logic [4:0] exp_q[$];
        logic [6:0] op;
        logic [4:0] e;
        int done_seen;
        for (int i = 0; i < fw; i++) exp_q.push_back({1'b0, 4'd1});
        exp_q.push_back({1'b1, 4'd1});
        exp_q.push_back({1'($urandom_range(0, 1)), 4'd2});
        case (cls)
            0: begin
                op = T_OP_R;
                exp_q.push_back({1'($urandom_range(0, 1)), 4'd3});
                exp_q.push_back({1'($urandom_range(0, 1)), 4'd6});
            end
            1: begin
                op = T_OP_LD;
                exp_q.push_back({1'($urandom_range(0, 1)), 4'd4});
                for (int i = 0; i < mw; i++) exp_q.push_back({1'b0, 4'd7});
                exp_q.push_back({1'b1, 4'd7});
                exp_q.push_back({1'($urandom_range(0, 1)), 4'd10});
            end
            2: begin
                op = T_OP_ST;
                exp_q.push_back({1'($urandom_range(0, 1)), 4'd4});
                for (int i = 0; i < mw; i++) exp_q.push_back({1'b0, 4'd8});
                exp_q.push_back({1'b1, 4'd8});
            end
            default: begin
                op = T_OP_BEQ;
                exp_q.push_back({1'($urandom_range(0, 1)), 4'd5});
            end
        endcase
        done_seen = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mem_ready = e[4];
            Opcode    = (e[3:0] == 4'd2) ? op : rnd_op();
            Zero      = 1'($urandom_range(0, 1));
            #4;
            check(nm, exp_out(e[3:0], e[4], Zero));
            done_seen += int'(instr_done);
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (done_seen != 1) begin
            n_fail++;
            $display("FAIL %s_done_count: got %0d required 1", nm, done_seen);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        mr;
        logic        z;
        logic [18:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [6:0] op, input logic mr,
                                input logic z, input logic [3:0] st);
        vec_t v;
        v.rst = rst;
        v.op  = op;
        v.mr  = mr;
        v.z   = z;
        v.exp = exp_out(st, mr, z);
        return v;
    endfunction

    initial begin
        vec_t vecs[20];
        int   cls;

        reset     = 1'b1;
        Opcode    = '0;
        Zero      = 1'b0;
        mem_ready = 1'b0;

        vecs[0]  = mk(1, 7'h00,    0, 0, 4'd0);
        vecs[1]  = mk(0, 7'h00,    1, 0, 4'd0);
        vecs[2]  = mk(0, 7'h7f,    1, 0, 4'd1);
        vecs[3]  = mk(0, T_OP_R,   0, 1, 4'd2);
        vecs[4]  = mk(0, T_OP_LD,  1, 0, 4'd3);
        vecs[5]  = mk(0, 7'h7f,    0, 1, 4'd6);
        vecs[6]  = mk(0, T_OP_ST,  0, 1, 4'd1);
        vecs[7]  = mk(0, T_OP_ST,  0, 0, 4'd1);
        vecs[8]  = mk(0, 7'h00,    1, 1, 4'd1);
        vecs[9]  = mk(0, T_OP_BEQ, 0, 1, 4'd2);
        vecs[10] = mk(0, 7'h7f,    0, 1, 4'd5);
        vecs[11] = mk(0, 7'h00,    1, 0, 4'd1);
        vecs[12] = mk(0, T_OP_BEQ, 1, 1, 4'd2);
        vecs[13] = mk(0, 7'h7f,    1, 0, 4'd5);
        vecs[14] = mk(0, 7'h00,    1, 1, 4'd1);
        vecs[15] = mk(0, T_OP_ST,  1, 0, 4'd2);
        vecs[16] = mk(0, T_OP_LD,  1, 0, 4'd4);
        vecs[17] = mk(0, T_OP_LD,  0, 1, 4'd8);
        vecs[18] = mk(0, T_OP_R,   1, 0, 4'd8);
        vecs[19] = mk(0, 7'h00,    0, 0, 4'd1);

        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            reset     = vecs[i].rst;
            Opcode    = vecs[i].op;
            mem_ready = vecs[i].mr;
            Zero      = vecs[i].z;
            #4;
            check($sformatf("vec%0d", i), vecs[i].exp);
            @(posedge clk);
            #1;
        end

        // Load with two wait cycles in MEMREAD and one in FETCH.
        run_instr(1, 1, 2, "load_wait");
        // Store with waits in MEMWRITE.
        run_instr(2, 0, 2, "store_wait");
        run_instr(0, 0, 0, "rtype");
        run_instr(3, 0, 0, "beq");

        // Illegal opcode: stuck for 20 cycles with only illegal_op raised.
        step("ill_fetch", 4'd1, 1'b1, rnd_op());
        step("ill_decode", 4'd2, 1'b1, 7'h7f);
        for (int i = 0; i < 20; i++) begin
            step("ill_hold", 4'd9, 1'($urandom_range(0, 1)), rnd_op());
        end
        do_reset("ill_reset");
        step("ill_restart", 4'd1, 1'b0, rnd_op());

        // Reset in the middle of a stalled store.
        step("rstmw_fetch", 4'd1, 1'b1, rnd_op());
        step("rstmw_decode", 4'd2, 1'b1, T_OP_ST);
        step("rstmw_addr", 4'd4, 1'b1, rnd_op());
        step("rstmw_wait", 4'd8, 1'b0, rnd_op());
        mem_ready = 1'b0;
        #4;
        check("rstmw_wait2", exp_out(4'd8, 1'b0, Zero));
        reset = 1'b1;
        #1;
        check("rstmw_async", exp_out(4'd0, 1'b0, 1'b0));
        mem_ready = 1'b1;
        #1;
        check("rstmw_hold", exp_out(4'd0, 1'b1, 1'b0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_ready = 1'b0;
        #3;
        check("rstmw_release", exp_out(4'd0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        step("rstmw_restart", 4'd1, 1'b0, rnd_op());

        // Randomized instruction stream.
        for (int i = 0; i < 60; i++) begin
            cls = $urandom_range(0, 3);
            run_instr(cls, $urandom_range(0, 2), $urandom_range(0, 2),
                      $sformatf("rnd%0d_c%0d", i, cls));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
